// File: rtl/npu_pkg.sv
// Purpose: shared types and clamp-limit helpers for the result write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: wb_state_t run-control states; sat_max/sat_min give the signed
//           clamp limits for a given output bit depth.
package npu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

   function automatic int sat_max(input int bit_depth);
      return (1 << (bit_depth - 1)) - 1;
   endfunction

   function automatic int sat_min(input int bit_depth);
      return -(1 << (bit_depth - 1));
   endfunction

endpackage

// File: rtl/requant_sat.sv
// Purpose: requantizer datapath -- rounding arithmetic right shift, optional ReLU, signed saturation.
// Latency: combinational; the rounding half and the clamp half are split so the caller can register between them.
// Backpressure: none, pure function of its inputs.
// Ports: acc/shift -> rnd (rounded, ACC_WIDTH+1 bits);
//        rnd_q/relu -> value (BIT_DEPTH signed) + sat_flag (set only when saturation clamped).
module requant_sat
   import npu_pkg::*;
#(
   parameter int ACC_WIDTH   = 32,
   parameter int BIT_DEPTH   = 8,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   input  logic        [SHIFT_WIDTH-1:0] shift,
   output logic signed [ACC_WIDTH:0]   rnd,
   input  logic signed [ACC_WIDTH:0]   rnd_q,
   input  logic                        relu,
   output logic signed [BIT_DEPTH-1:0] value,
   output logic                        sat_flag
);

   localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'(sat_max(BIT_DEPTH));
   localparam logic signed [ACC_WIDTH:0] MIN_V = (ACC_WIDTH+1)'(sat_min(BIT_DEPTH));

   logic signed [ACC_WIDTH:0] acc_ext;
   logic signed [ACC_WIDTH:0] bias;
   logic signed [ACC_WIDTH:0] sum;

   // One extra bit of headroom so acc + half-LSB can never wrap.
   always_comb begin
      acc_ext = {acc[ACC_WIDTH-1], acc};
      bias    = '0;
      if (shift != '0) begin
         bias = (ACC_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
      end
      sum = acc_ext + bias;
      rnd = sum >>> shift;
   end

   // ReLU takes priority: a negative value zeroed by ReLU is not a saturation event.
   always_comb begin
      value    = rnd_q[BIT_DEPTH-1:0];
      sat_flag = 1'b0;
      if (relu && (rnd_q < 0)) begin
         value = '0;
      end else if (rnd_q > MAX_V) begin
         value    = MAX_V[BIT_DEPTH-1:0];
         sat_flag = 1'b1;
      end else if (rnd_q < MIN_V) begin
         value    = MIN_V[BIT_DEPTH-1:0];
         sat_flag = 1'b1;
      end
   end

endmodule

// File: rtl/res_writeback.sv
// Purpose: write-back stage -- requantizes accepted accumulator results and writes them to the result buffer at wrapping addresses.
// Latency: transfer at edge t -> wr_en/data_out/wr_addr visible after edge t+2; one result per cycle sustained.
// Backpressure: acc_ready only limits the run length; the buffer never stalls, so every transfer yields exactly one write.
// Ports: clk/rst_n (sync, active low); start + cfg_* captured in IDLE; acc_in/acc_valid/acc_ready input handshake;
//        wr_addr/wr_en/data_out buffer write port; busy, done (1-cycle pulse), sat_cnt (saturations this run).
module res_writeback
   import npu_pkg::*;
#(
   parameter int ACC_WIDTH   = 32,
   parameter int BIT_DEPTH   = 8,
   parameter int ADDR_WIDTH  = 10,
   parameter int DEPTH       = 26,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]  cfg_count,
   input  logic [SHIFT_WIDTH-1:0] cfg_shift,
   input  logic                   cfg_relu,
   input  logic [ACC_WIDTH-1:0]   acc_in,
   input  logic                   acc_valid,
   output logic                   acc_ready,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   output logic                   wr_en,
   output logic [BIT_DEPTH-1:0]   data_out,
   output logic                   busy,
   output logic                   done,
   output logic [ADDR_WIDTH-1:0]  sat_cnt
);

   wb_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0]  count_q;
   logic [SHIFT_WIDTH-1:0] shift_q;
   logic                   relu_q;
   logic [ADDR_WIDTH-1:0]  acc_cnt;   // results accepted this run
   logic [ADDR_WIDTH-1:0]  wr_cnt;    // results written this run
   logic [ADDR_WIDTH-1:0]  addr_ptr;  // address of the next write

   // Capture register keeps the rounding adder off the acc_in input path.
   logic                        cap_vld;
   logic signed [ACC_WIDTH-1:0] cap_acc;
   logic                        s1_vld;
   logic signed [ACC_WIDTH:0]   s1_rnd;

   logic signed [ACC_WIDTH:0]   rnd;
   logic signed [BIT_DEPTH-1:0] sat_val;
   logic                        sat_flag;
   logic                        xfer;

   assign acc_ready = (state == RUN) && (acc_cnt < count_q);
   assign xfer      = acc_valid && acc_ready;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == DONE);

   requant_sat #(
      .ACC_WIDTH   (ACC_WIDTH),
      .BIT_DEPTH   (BIT_DEPTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_requant (
      .acc      (cap_acc),
      .shift    (shift_q),
      .rnd      (rnd),
      .rnd_q    (s1_rnd),
      .relu     (relu_q),
      .value    (sat_val),
      .sat_flag (sat_flag)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (cfg_count == '0) ? DONE : RUN;
         RUN:   if (xfer && ((acc_cnt + ADDR_WIDTH'(1)) == count_q)) state_nxt = DRAIN;
         // wr_cnt already includes the write currently on the port.
         DRAIN: if (wr_en && (wr_cnt == count_q)) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count_q  <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
         acc_cnt  <= '0;
         wr_cnt   <= '0;
         addr_ptr <= '0;
         cap_vld  <= 1'b0;
         cap_acc  <= '0;
         s1_vld   <= 1'b0;
         s1_rnd   <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         data_out <= '0;
         sat_cnt  <= '0;
      end else begin
         state <= state_nxt;

         if ((state == IDLE) && start) begin
            count_q  <= cfg_count;
            shift_q  <= cfg_shift;
            relu_q   <= cfg_relu;
            addr_ptr <= cfg_base_addr;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            sat_cnt  <= '0;
         end

         cap_vld <= xfer;
         if (xfer) begin
            cap_acc <= acc_in;
            acc_cnt <= acc_cnt + ADDR_WIDTH'(1);
         end

         s1_vld <= cap_vld;
         if (cap_vld) begin
            s1_rnd <= rnd;
         end

         // Data and address hold their last value between writes.
         wr_en <= s1_vld;
         if (s1_vld) begin
            data_out <= sat_val;
            wr_addr  <= addr_ptr;
            addr_ptr <= (addr_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_ptr + ADDR_WIDTH'(1);
            wr_cnt   <= wr_cnt + ADDR_WIDTH'(1);
            if (sat_flag) begin
               sat_cnt <= sat_cnt + ADDR_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_res_writeback.sv
// Purpose: self-checking bench for res_writeback using an expected-write scoreboard.
// Latency: expects each write two edges after its transfer edge; done one cycle after the last write.
// Backpressure: stimulus only counts a transfer when acc_ready is high at drive time.
module tb_res_writeback;
   import npu_pkg::*;

   localparam int ACC_WIDTH   = 32;
   localparam int BIT_DEPTH   = 8;
   localparam int ADDR_WIDTH  = 10;
   localparam int DEPTH       = 26;
   localparam int SHIFT_WIDTH = 5;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start;
   logic [ADDR_WIDTH-1:0]  cfg_base_addr;
   logic [ADDR_WIDTH-1:0]  cfg_count;
   logic [SHIFT_WIDTH-1:0] cfg_shift;
   logic                   cfg_relu;
   logic [ACC_WIDTH-1:0]   acc_in;
   logic                   acc_valid;
   logic                   acc_ready;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic                   wr_en;
   logic [BIT_DEPTH-1:0]   data_out;
   logic                   busy;
   logic                   done;
   logic [ADDR_WIDTH-1:0]  sat_cnt;

   res_writeback #(
      .ACC_WIDTH   (ACC_WIDTH),
      .BIT_DEPTH   (BIT_DEPTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DEPTH       (DEPTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_count     (cfg_count),
      .cfg_shift     (cfg_shift),
      .cfg_relu      (cfg_relu),
      .acc_in        (acc_in),
      .acc_valid     (acc_valid),
      .acc_ready     (acc_ready),
      .wr_addr       (wr_addr),
      .wr_en         (wr_en),
      .data_out      (data_out),
      .busy          (busy),
      .done          (done),
      .sat_cnt       (sat_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     addr;
      longint data;
      int     cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int n_cmp = 0;
   int n_err = 0;
   int exp_addr;
   int exp_sat;
   int exp_shift;
   bit exp_relu;
   int exp_done;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference requantizer: round half up, arithmetic shift, ReLU before 8-bit clamp.
   function automatic longint model(input longint acc, input int sh, input bit relu, output bit sat);
      longint r;
      sat = 1'b0;
      if (sh > 0) r = (acc + (longint'(1) << (sh - 1))) >>> sh;
      else        r = acc;
      if (relu && r < 0) r = 0;
      else if (r > 127) begin
         r   = 127;
         sat = 1'b1;
      end else if (r < -128) begin
         r   = -128;
         sat = 1'b1;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_wr", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("wr_addr", wr_addr, mon_e.addr);
            chk("data_out", $signed(data_out), mon_e.data);
            chk("wr_latency", cyc, mon_e.cyc);
         end
      end
   end

   // Called just after a negedge; start is sampled at the next posedge.
   task automatic do_start(input int base, input int count, input int sh, input bit relu);
      cfg_base_addr = ADDR_WIDTH'(base);
      cfg_count     = ADDR_WIDTH'(count);
      cfg_shift     = SHIFT_WIDTH'(sh);
      cfg_relu      = relu;
      start         = 1'b1;
      exp_addr      = base;
      exp_shift     = sh;
      exp_relu      = relu;
      exp_sat       = 0;
      exp_done      = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input bit v, input int acc);
      bit     s;
      longint d;
      acc_valid = v;
      acc_in    = ACC_WIDTH'(acc);
      if (v && acc_ready) begin
         d = model(longint'(acc), exp_shift, exp_relu, s);
         if (s) exp_sat++;
         sb.push_back('{exp_addr, d, cyc + 3});
         exp_done = cyc + 4;
         exp_addr = (exp_addr == DEPTH - 1) ? 0 : exp_addr + 1;
      end
      @(negedge clk);
      acc_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("done_cycle", cyc, exp_done);
         chk("busy_in_done", busy, 0);
         chk("sat_cnt", sat_cnt, exp_sat);
         chk("sb_drained", sb.size(), 0);
      end
      @(negedge clk);
   endtask

   task automatic check_quiet(input string pfx);
      chk({pfx, "_wr_en"}, wr_en, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_acc_ready"}, acc_ready, 0);
      chk({pfx, "_wr_addr"}, wr_addr, 0);
      chk({pfx, "_data_out"}, data_out, 0);
      chk({pfx, "_sat_cnt"}, sat_cnt, 0);
      chk({pfx, "_state"}, dut.state, IDLE);
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      cfg_base_addr = '0;
      cfg_count     = '0;
      cfg_shift     = '0;
      cfg_relu      = 1'b0;
      acc_in        = '0;
      acc_valid     = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic pass-through, back-to-back.
      do_start(0, 4, 0, 0);
      for (int i = 1; i <= 4; i++) send(1'b1, i);
      wait_done();

      // Rounding.
      do_start(0, 3, 4, 0);
      send(1'b1, 24);
      send(1'b1, -24);
      send(1'b1, 7);
      wait_done();
      do_start(10, 1, 1, 0);
      send(1'b1, 3);
      wait_done();

      // Saturation, then ReLU (ReLU zeroing is not a saturation).
      do_start(0, 2, 0, 0);
      send(1'b1, 1000);
      send(1'b1, -1000);
      wait_done();
      do_start(2, 3, 0, 1);
      send(1'b1, 1000);
      send(1'b1, -1000);
      send(1'b1, -5);
      wait_done();

      // Address wrap; extra valids after the run's quota are ignored.
      do_start(24, 4, 0, 0);
      for (int i = 5; i <= 8; i++) send(1'b1, i);
      chk("ready_dropped", acc_ready, 0);
      send(1'b1, 9);
      send(1'b1, 10);
      wait_done();

      // Bubbles in the input stream.
      do_start(7, 3, 2, 0);
      send(1'b1, 40);
      send(1'b0, 0);
      send(1'b1, -40);
      send(1'b0, 0);
      send(1'b0, 0);
      send(1'b1, 100);
      wait_done();

      // Empty run.
      do_start(3, 0, 0, 0);
      wait_done();

      // start during RUN must not disturb the active run.
      do_start(5, 3, 0, 0);
      send(1'b1, 10);
      cfg_base_addr = ADDR_WIDTH'(20);
      cfg_count     = ADDR_WIDTH'(1);
      start         = 1'b1;
      send(1'b1, 11);
      start = 1'b0;
      send(1'b1, 12);
      wait_done();

      // Reset with two results in flight: nothing may be written afterwards.
      do_start(0, 4, 0, 0);
      send(1'b1, 50);
      send(1'b1, 60);
      rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_quiet("post_reset");

      do_start(1, 2, 0, 0);
      send(1'b1, -3);
      send(1'b1, 77);
      wait_done();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
